// File: rtl/key_event_gen_pkg.sv
// Shared definitions for the key event generator: FSM state encodings and a
// small decode helper used by the top level.
package key_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_LOCK   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HELD   = 2'd2,
    ST_REPEAT = 2'd3
  } key_state_t;

  function automatic logic is_held(input key_state_t s);
    return (s == ST_HELD) || (s == ST_REPEAT);
  endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Hold-duration counter with clear, load-one and increment controls, plus a
// compare against a caller-supplied terminal value.
module key_hold_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load_one,
  input  logic               incr,
  input  logic [TIMER_W-1:0] term,
  output logic [TIMER_W-1:0] count,
  output logic               at_term
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= TIMER_W'(1);
    end else if (incr) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/key_event_gen.sv
// Converts a debounced active-low key level into single-cycle press, release,
// long-press and auto-repeat events, and counts accepted presses.
module key_event_gen
  import key_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int TIMER_W       = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             key_held,
  output logic [CNT_W-1:0] press_cnt
);

  localparam logic [TIMER_W-1:0] LONG_T   = TIMER_W'(LONG_CYCLES);
  localparam logic [TIMER_W-1:0] REPEAT_T = TIMER_W'(REPEAT_CYCLES);

  key_state_t         state, state_nxt;
  logic               press_nxt, release_nxt, long_nxt, repeat_nxt;
  logic               timer_clear, timer_load, timer_incr;
  logic [TIMER_W-1:0] timer_term;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_at_term;

  key_hold_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .load_one (timer_load),
    .incr     (timer_incr),
    .term     (timer_term),
    .count    (timer_count),
    .at_term  (timer_at_term)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    timer_clear = 1'b0;
    timer_load  = 1'b0;
    timer_incr  = 1'b0;
    timer_term  = LONG_T;

    unique case (state)
      ST_LOCK: begin
        // A key already down when reset ends must be released before it counts.
        if (key_n) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!key_n) begin
          state_nxt  = ST_HELD;
          press_nxt  = 1'b1;
          timer_load = 1'b1;
        end
      end
      ST_HELD: begin
        timer_term = LONG_T;
        if (key_n) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          timer_clear = 1'b1;
        end else if (timer_at_term) begin
          state_nxt  = ST_REPEAT;
          long_nxt   = 1'b1;
          timer_load = 1'b1;
        end else begin
          timer_incr = 1'b1;
        end
      end
      ST_REPEAT: begin
        timer_term = REPEAT_T;
        if (key_n) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          timer_clear = 1'b1;
        end else if (timer_at_term) begin
          repeat_nxt = 1'b1;
          timer_load = 1'b1;
        end else begin
          timer_incr = 1'b1;
        end
      end
      default: state_nxt = ST_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_LOCK;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      key_held      <= 1'b0;
      press_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      key_held      <= is_held(state_nxt);
      if (press_nxt) press_cnt <= press_cnt + 1'b1;
    end
  end

endmodule
